// File: rtl/seg_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler: state codes,
// the idle display value and the dwell/blank counter width helper.
package seg_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHOW  = SHOW,
    ST_BLANK = BLANK
  } sched_state_t;

  localparam logic [15:0] SEG_IDLE_VALUE = 16'h0000;

  // The counter only ever holds (cycles - 1), so $clog2 of the larger period suffices.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping,
// and returns the first requesting source as one-hot, index and valid.
module seg_rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!gnt_vld && req[i] && (i == (int'(ptr) + k) % NUM_SRC)) begin
          gnt_vld = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seven_seg_scheduler.sv
// Time-shares the 4-digit seven-segment display between NUM_SRC requesters
// with round-robin grants, fixed dwell and blank gaps.
// Optional macro SEG_SCHED_PREEMPT_EN: source 0 preempts any other message.
//
// state | meaning
// IDLE  | nothing shown, IDLE_VALUE on display, waiting for a request
// SHOW  | granted value on display for DWELL_CYCLES cycles
// BLANK | digits off for BLANK_CYCLES cycles before the next grant
module seven_seg_scheduler
  import seg_sched_pkg::*;
#(
  parameter int          NUM_SRC      = 4,
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter int          BLANK_CYCLES = 5_000_000,
  parameter logic [15:0] IDLE_VALUE   = SEG_IDLE_VALUE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      req,
  input  logic [16*NUM_SRC-1:0]   data_in,
  output logic [NUM_SRC-1:0]      ack,
  output logic [15:0]             disp_data,
  output logic                    disp_blank,
  output logic                    busy,
  output logic [2:0]              cur_src
);

  localparam int            CW         = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

  sched_state_t        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          ptr_q, ptr_d, ptr_next;
  logic [NUM_SRC-1:0]  ack_d;
  logic [15:0]         data_d;
  logic                blank_d;
  logic [2:0]          src_d;

  logic [NUM_SRC-1:0]  req_eff;
  logic [NUM_SRC-1:0]  gnt;
  logic [2:0]          gnt_idx;
  logic                gnt_vld;
  logic [15:0]         gnt_data;
  logic                preempt;
  logic                do_grant;
  logic                do_idle;

  // A source still holding req in its own ack cycle has not yet seen the ack.
  assign req_eff = req & ~ack;

  seg_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (req_eff),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign ptr_next = 3'((int'(gnt_idx) + 1) % NUM_SRC);

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) gnt_data = data_in[16*i +: 16];
    end
  end

`ifdef SEG_SCHED_PREEMPT_EN
  assign preempt = req_eff[0] &&
                   (((state_q == ST_SHOW) && (cur_src != 3'd0)) || (state_q == ST_BLANK));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    data_d   = disp_data;
    blank_d  = disp_blank;
    src_d    = cur_src;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    if (preempt) begin
      // Urgent grant leaves the round-robin pointer untouched.
      state_d = ST_SHOW;
      cnt_d   = DWELL_LOAD;
      ack_d   = NUM_SRC'(1);
      data_d  = data_in[15:0];
      blank_d = 1'b0;
      src_d   = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          do_grant = gnt_vld;
        end
        ST_SHOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (|req_eff) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            blank_d = 1'b1;
          end else begin
            do_idle = 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (gnt_vld) begin
            do_grant = 1'b1;
          end else begin
            do_idle = 1'b1;
          end
        end
        default: begin
          do_idle = 1'b1;
        end
      endcase
    end

    if (do_grant) begin
      state_d = ST_SHOW;
      cnt_d   = DWELL_LOAD;
      ack_d   = gnt;
      data_d  = gnt_data;
      blank_d = 1'b0;
      src_d   = gnt_idx;
      ptr_d   = ptr_next;
    end
    if (do_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      data_d  = IDLE_VALUE;
      blank_d = 1'b0;
      src_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ack        <= '0;
      disp_data  <= IDLE_VALUE;
      disp_blank <= 1'b0;
      cur_src    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ack        <= ack_d;
      disp_data  <= data_d;
      disp_blank <= blank_d;
      cur_src    <= src_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Self-checking bench for seven_seg_scheduler: a message-level reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_seven_seg_scheduler;

  localparam int          N  = 4;
  localparam int          DW = 8;
  localparam int          BW = 2;
  localparam logic [15:0] IV = 16'h0000;
`ifdef SEG_SCHED_PREEMPT_EN
  localparam int PRE_N = 1;
`else
  localparam int PRE_N = 9;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [16*N-1:0]   data_in;
  logic [N-1:0]      ack;
  logic [15:0]       disp_data;
  logic              disp_blank;
  logic              busy;
  logic [2:0]        cur_src;

  logic [15:0]       vals [N];
  logic [15:0]       snap [N];
  logic [N-1:0]      hold = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = nothing shown, 1 = message on display, 2 = gap.
  int           m_mode, m_left, m_ptr, m_src;
  logic [15:0]  m_data;
  logic [N-1:0] m_ack;

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int i = 0; i < N; i++) data_in[16*i +: 16] = vals[i];
  end

  seven_seg_scheduler #(
    .NUM_SRC(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BW), .IDLE_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .disp_data(disp_data), .disp_blank(disp_blank), .busy(busy), .cur_src(cur_src)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_ptr = 0; m_src = 0; m_data = IV; m_ack = '0;
  endtask

  task automatic show_msg(input int g);
    m_mode = 1; m_left = DW; m_data = snap[g]; m_src = g; m_ack[g] = 1'b1;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int g;
    bit pre;
    m_ack = '0;
    pre = 1'b0;
`ifdef SEG_SCHED_PREEMPT_EN
    pre = r[0] && ((m_mode == 1 && m_src != 0) || m_mode == 2);
`endif
    if (pre) begin
      show_msg(0);
    end else if (m_mode == 0) begin
      g = pick(r, m_ptr);
      if (g >= 0) begin show_msg(g); m_ptr = (g + 1) % N; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        g = (m_mode == 2) ? pick(r, m_ptr) : -1;
        if (m_mode == 1 && r != '0) begin
          m_mode = 2; m_left = BW;
        end else if (g >= 0) begin
          show_msg(g); m_ptr = (g + 1) % N;
        end else begin
          m_mode = 0; m_data = IV; m_src = 0;
        end
      end
    end
  endtask

  // One clock: model consumes the inputs seen before the edge, outputs compared after it.
  task automatic tick();
    logic [N-1:0] r;
    r = req & ~m_ack;
    for (int i = 0; i < N; i++) snap[i] = vals[i];
    @(posedge clk);
    model_step(r);
    #1;
    check("ack", ack, m_ack);
    check("disp_data", disp_data, m_data);
    check("disp_blank", disp_blank, (m_mode == 2));
    check("busy", busy, (m_mode != 0));
    check("cur_src", cur_src, 3'(m_src));
    for (int i = 0; i < N; i++)
      if (m_ack[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic wait_ack(input int idx, input int bound, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < bound) begin
      tick();
      n++;
      if (ack[idx]) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin tick(); n++; end while (busy && n < bound);
    check("idle_timeout", busy, 1'b0);
  endtask

  int n, cnt_vis, cnt_blank, cnt_ack1, c0;
  logic [15:0] seq [$];
  bit found;

  initial begin
    for (int i = 0; i < N; i++) vals[i] = '0;
    model_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_disp_data", disp_data, 16'h0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_blank", disp_blank, 1'b0);
    check("rst_cur_src", cur_src, 3'd0);

    // Single request from source 2.
    vals[2] = 16'hBEEF; req[2] = 1'b1;
    tick();
    check("single_ack", ack, 4'b0100);
    check("single_data", disp_data, 16'hBEEF);
    cnt_vis = (disp_data == 16'hBEEF && busy) ? 1 : 0;
    cnt_blank = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (disp_data == 16'hBEEF && busy) cnt_vis++;
      if (disp_blank) cnt_blank++;
    end
    check("single_dwell", cnt_vis, 8);
    check("single_noblank", cnt_blank, 0);
    check("single_idle_data", disp_data, 16'h0000);

    // Withdrawal of source 1 during source 2's message.
    vals[2] = 16'h2222; req[2] = 1'b1;
    wait_ack(2, 5, n);
    check("wd_ack_latency", n, 1);
    tick();
    vals[1] = 16'h0101; req[1] = 1'b1;
    repeat (3) tick();
    req[1] = 1'b0;
    cnt_ack1 = 0; cnt_blank = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ack[1]) cnt_ack1++;
      if (disp_blank) cnt_blank++;
    end
    check("wd_no_ack1", cnt_ack1, 0);
    check("wd_no_blank", cnt_blank, 0);
    check("wd_idle", busy, 1'b0);

    // Reset mid-message, then all four sources at once.
    vals[1] = 16'h0BAD; req[1] = 1'b1;
    wait_ack(1, 5, n);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_data", disp_data, 16'h0000);
    check("mid_rst_ack", ack, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_blank", disp_blank, 1'b0);
    model_reset();
    req = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    req = 4'b1111;
    tick();
    check("all_first_ack", ack, 4'b0001);
    seq.delete();
    seq.push_back(disp_data);
    cnt_blank = 0;
    for (int k = 0; k < 80 && busy; k++) begin
      tick();
      if (ack != '0) begin
        seq.push_back(disp_data);
        check("all_ack_onehot", $onehot(ack), 1'b1);
      end
      if (disp_blank) cnt_blank++;
    end
    check("all_count", seq.size(), 4);
    if (seq.size() == 4) begin
      check("all_seq0", seq[0], 16'h1111);
      check("all_seq1", seq[1], 16'h2222);
      check("all_seq2", seq[2], 16'h3333);
      check("all_seq3", seq[3], 16'h4444);
    end
    check("all_blank_cycles", cnt_blank, 6);
    check("all_idle", busy, 1'b0);

    // Fairness: source 0 held, source 3 pulsed.
    hold[0] = 1'b1; vals[0] = 16'h000A; req[0] = 1'b1;
    wait_ack(0, 5, n);
    check("fair_first_ack", n, 1);
    tick(); tick();
    vals[3] = 16'h3003; req[3] = 1'b1;
    c0 = 0; found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (ack[0]) c0++;
      if (ack[3]) found = 1'b1;
    end
    check("fair_src3_served", found, 1'b1);
    check("fair_src0_before", (c0 <= 1), 1'b1);
    hold[0] = 1'b0; req[0] = 1'b0;
    wait_idle(60);

    // Urgent source 0 while source 3 is on display.
    vals[3] = 16'h3333; req[3] = 1'b1;
    wait_ack(3, 5, n);
    check("pre_src3_ack", n, 1);
    tick();
    vals[0] = 16'hA5A5; req[0] = 1'b1;
    wait_ack(0, 30, n);
    check("pre_latency", n, PRE_N);
    check("pre_data", disp_data, 16'hA5A5);
    check("pre_blank", disp_blank, 1'b0);
    wait_idle(60);

    // Random traffic with holds, re-requests and withdrawals.
    for (int k = 0; k < 1500; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1; vals[i] = 16'($urandom);
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 9) == 0) begin
            vals[i] = 16'($urandom); req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
